// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the icache and dcache, routing in-order read responses back to their owner
// Ports: ic_* / dc_* are the two cache-side mem_req/mem_resp handshakes, mem_* is the single memory port,
// mem_resp_data_out broadcasts read data to both caches. Define MEM_ARB_RR_EN for round-robin; the default build uses fixed dcache priority.
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_mem_req_valid,
  output logic                   ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                   ic_mem_req_rw,
  input  logic                   ic_mem_req_data_valid,
  output logic                   ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                   ic_mem_resp_valid,
  input  logic                   dc_mem_req_valid,
  output logic                   dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                   dc_mem_req_rw,
  input  logic                   dc_mem_req_data_valid,
  output logic                   dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                   dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data_out,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int PW = $clog2(MAX_OUTST);
  typedef enum logic [1:0] {IDLE, ADDR, WDATA} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d;
  logic [MAX_OUTST-1:0] own_q, own_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic full, ic_el, dc_el, pick, sel, s_v, s_rw, s_dv, acc, dhs, push, pop;
`ifdef MEM_ARB_RR_EN
  logic rr_q, rr_d;
`endif
  // sel: 0 = icache, 1 = dcache; only free to change in IDLE
  always_comb begin
    full = cnt_q == (PW+1)'(MAX_OUTST);
    // a read cannot win while the owner FIFO is full, but a write still can
    ic_el = ic_mem_req_valid & (ic_mem_req_rw | !full);
    dc_el = dc_mem_req_valid & (dc_mem_req_rw | !full);
`ifdef MEM_ARB_RR_EN
    pick = (ic_el & dc_el) ? rr_q : dc_el;
`else
    pick = dc_el;
`endif
    sel = (state_q == IDLE) ? pick : gnt_q;
    s_v = sel ? dc_mem_req_valid : ic_mem_req_valid;
    s_rw = sel ? dc_mem_req_rw : ic_mem_req_rw;
    s_dv = sel ? dc_mem_req_data_valid : ic_mem_req_data_valid;
    mem_req_addr = sel ? dc_mem_req_addr : ic_mem_req_addr;
    mem_req_rw = s_rw;
    mem_req_data_bits = sel ? dc_mem_req_data_bits : ic_mem_req_data_bits;
    mem_req_data_mask = sel ? dc_mem_req_data_mask : ic_mem_req_data_mask;
    mem_req_valid = !reset & (state_q != WDATA) & s_v & (s_rw | !full);
    acc = mem_req_valid & mem_req_ready;
    // write data is only offered once its address is accepted (same cycle or later in WDATA)
    mem_req_data_valid = !reset & s_dv & ((state_q == WDATA) | (acc & s_rw));
    dhs = mem_req_data_valid & mem_req_data_ready;
    ic_mem_req_ready = acc & !sel;
    dc_mem_req_ready = acc & sel;
    ic_mem_req_data_ready = dhs & !sel;
    dc_mem_req_data_ready = dhs & sel;
    pop = !reset & mem_resp_valid & (cnt_q != '0);
    push = acc & !s_rw;
    ic_mem_resp_valid = pop & !own_q[rp_q];
    dc_mem_resp_valid = pop & own_q[rp_q];
    mem_resp_data_out = mem_resp_data;
    state_d = (state_q == WDATA) ? (dhs ? IDLE : WDATA) :
              acc ? ((s_rw & !dhs) ? WDATA : IDLE) :
              (mem_req_valid | (state_q == ADDR)) ? ADDR : IDLE;
    gnt_d = sel;
    own_d = own_q;
    if (push) own_d[wp_q] = sel;
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
`ifdef MEM_ARB_RR_EN
    rr_d = acc ? !sel : rr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      own_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      own_q <= own_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
`ifdef MEM_ARB_RR_EN
      rr_q <= rr_d;
`endif
    end
  end
endmodule
